// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: register file geometry and bypass-select encoding.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // fwd_sel value meaning "read from the register file"; k>0 selects stage k-1.
    localparam int unsigned FWD_RF = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_port_sel.sv
// Per-read-port bypass priority match: youngest writing stage with a matching destination wins.
module fwd_port_sel
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [REG_ADDR_W-1:0]              rd_addr,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD-1:0]                 fwd_wen,
    input  logic [NUM_FWD-1:0]                 fwd_dvalid,
    output logic [SEL_W-1:0]                   sel,
    output logic                               not_ready
);

    // Scan oldest to youngest so the lowest-index match is the one left standing; x0 never matches.
    always_comb begin
        sel       = SEL_W'(FWD_RF);
        not_ready = 1'b0;
        if (rd_addr != '0) begin
            for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
                if (fwd_wen[k] && (fwd_waddr[k] == rd_addr)) begin
                    sel       = SEL_W'(k + 1);
                    not_ready = ~fwd_dvalid[k];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: bypass selection, load-use / latency stall, and stall statistics.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned LAT_W   = 3,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RD-1:0][REG_ADDR_W-1:0]  rd_addr,
    input  logic [NUM_RD-1:0]                  rd_used,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD-1:0]                 fwd_wen,
    input  logic [NUM_FWD-1:0]                 fwd_dvalid,
    input  logic                               iss_valid,
    input  logic [REG_ADDR_W-1:0]              iss_rd,
    input  logic                               iss_wen,
    input  logic [LAT_W-1:0]                   iss_lat,
    input  logic                               flush,
    output logic [NUM_RD-1:0][SEL_W-1:0]       fwd_sel,
    output logic                               stall,
    output logic [NUM_REGS-1:0]                pending,
    output logic [CNT_W-1:0]                   stall_cycles
);

    logic [NUM_RD-1:0]                 not_ready;
    logic [NUM_REGS-1:0][LAT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]                  stall_cycles_q, stall_cycles_d;
    logic                              issue_load;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_port_sel #(
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W)
        ) u_sel (
            .rd_addr    (rd_addr[p]),
            .fwd_waddr  (fwd_waddr),
            .fwd_wen    (fwd_wen),
            .fwd_dvalid (fwd_dvalid),
            .sel        (fwd_sel[p]),
            .not_ready  (not_ready[p])
        );
    end

    // Pending bitmap straight from the countdowns, so a count of 0 releases the stall that cycle.
    always_comb begin
        pending = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            pending[r] = (count_q[r] != '0);
        end
    end

    // Stall when a consumed operand is still counting down or its bypass source is not ready yet.
    always_comb begin
        stall = 1'b0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            if (rd_used[p] && (rd_addr[p] != '0) && (pending[rd_addr[p]] || not_ready[p])) begin
                stall = 1'b1;
            end
        end
    end

    assign issue_load = iss_valid && !stall && iss_wen && (iss_rd != '0);

    // Countdown next state: decrement all, issue load overrides its own entry, flush clears all.
    always_comb begin
        count_d = count_q;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            if (count_q[r] != '0) begin
                count_d[r] = count_q[r] - LAT_W'(1);
            end
        end
        if (issue_load) begin
            count_d[iss_rd] = iss_lat;
        end
        if (flush) begin
            count_d = '0;
        end
        count_d[0] = '0;
    end

    // Stall statistics: count stalled, non-flushed cycles and stick at all-ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !flush && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State registers; reset discards every outstanding latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q        <= '0;
            stall_cycles_q <= '0;
        end else begin
            count_q        <= count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a behavioural scoreboard model.
module tb_hazard_scoreboard;

    localparam int unsigned NUM_RD  = 2;
    localparam int unsigned NUM_FWD = 2;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SEL_W   = $clog2(NUM_FWD + 1);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NUM_RD-1:0][4:0]       rd_addr;
    logic [NUM_RD-1:0]            rd_used;
    logic [NUM_FWD-1:0][4:0]      fwd_waddr;
    logic [NUM_FWD-1:0]           fwd_wen;
    logic [NUM_FWD-1:0]           fwd_dvalid;
    logic                         iss_valid;
    logic [4:0]                   iss_rd;
    logic                         iss_wen;
    logic [LAT_W-1:0]             iss_lat;
    logic                         flush;
    logic [NUM_RD-1:0][SEL_W-1:0] fwd_sel;
    logic                         stall;
    logic [31:0]                  pending;
    logic [CNT_W-1:0]             stall_cycles;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: remaining cycles per register and the stall counter.
    int          m_cnt[32];
    int unsigned m_sc;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_RD  (NUM_RD),
        .NUM_FWD (NUM_FWD),
        .LAT_W   (LAT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr      (rd_addr),
        .rd_used      (rd_used),
        .fwd_waddr    (fwd_waddr),
        .fwd_wen      (fwd_wen),
        .fwd_dvalid   (fwd_dvalid),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_wen      (iss_wen),
        .iss_lat      (iss_lat),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .pending      (pending),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int m_sel(input int p);
        if (rd_addr[p] == 0) return 0;
        for (int k = 0; k < int'(NUM_FWD); k++)
            if (fwd_wen[k] && fwd_waddr[k] == rd_addr[p]) return k + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        for (int p = 0; p < int'(NUM_RD); p++) begin
            int s;
            if (!rd_used[p] || rd_addr[p] == 0) continue;
            if (m_cnt[rd_addr[p]] != 0) return 1'b1;
            s = m_sel(p);
            if (s != 0 && !fwd_dvalid[s-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (m_cnt[r] != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_sc = 0;
    endtask

    task automatic compare_all(input string tag);
        for (int p = 0; p < int'(NUM_RD); p++)
            chk($sformatf("%s.fwd_sel%0d", tag, p), 32'(fwd_sel[p]), 32'(m_sel(p)));
        chk({tag, ".stall"}, 32'(stall), 32'(m_stall()));
        chk({tag, ".pending"}, pending, m_pending());
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), m_sc);
    endtask

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        bit st = m_stall();
        @(posedge clk);
        if (flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
            if (iss_valid && !st && iss_wen && iss_rd != 0) m_cnt[iss_rd] = int'(iss_lat);
        end
        if (st && !flush && m_sc < CNT_MAX) m_sc++;
        #1;
    endtask

    task automatic idle_inputs();
        rd_addr = '0; rd_used = '0; fwd_waddr = '0; fwd_wen = '0; fwd_dvalid = '1;
        iss_valid = 0; iss_rd = '0; iss_wen = 0; iss_lat = '0; flush = 0;
    endtask

    initial begin
        int sc0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #2;
        chk("reset.pending", pending, 32'h0);
        chk("reset.stall_cycles", 32'(stall_cycles), 32'h0);
        chk("reset.stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        // Issue x9 with latency 3, then consume it.
        iss_valid = 1; iss_rd = 5'd9; iss_wen = 1; iss_lat = 3'd3;
        @(negedge clk); compare_all("iss9");
        tick();
        iss_valid = 0;
        rd_addr[0] = 5'd9; rd_used[0] = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_all($sformatf("lat9_c%0d", i));
            chk($sformatf("lat9_stall%0d", i), 32'(stall), 32'h1);
            tick();
        end
        @(negedge clk);
        compare_all("lat9_done");
        chk("lat9_pending9", 32'(pending[9]), 32'h0);
        chk("lat9_stall_off", 32'(stall), 32'h0);
        chk("lat9_stall_cycles", 32'(stall_cycles), 32'd3);
        tick();

        // Youngest stage wins.
        idle_inputs();
        rd_addr[0] = 5'd5; rd_used[0] = 1;
        fwd_waddr[0] = 5'd5; fwd_waddr[1] = 5'd5; fwd_wen = '1;
        @(negedge clk); compare_all("youngest");
        chk("youngest_sel", 32'(fwd_sel[0]), 32'd1);
        tick();

        // x0 never forwards or stalls.
        idle_inputs();
        rd_used = '1; fwd_wen = '1; fwd_dvalid = '0;
        @(negedge clk); compare_all("x0");
        chk("x0_sel0", 32'(fwd_sel[0]), 32'd0);
        chk("x0_sel1", 32'(fwd_sel[1]), 32'd0);
        chk("x0_stall", 32'(stall), 32'd0);
        tick();

        // Load-use: one stall cycle, then bypass from WB.
        idle_inputs();
        sc0 = int'(m_sc);
        fwd_waddr[0] = 5'd7; fwd_wen[0] = 1; fwd_dvalid[0] = 0;
        rd_addr[1] = 5'd7; rd_used[1] = 1;
        @(negedge clk); compare_all("loaduse");
        chk("loaduse_stall", 32'(stall), 32'd1);
        tick();
        fwd_wen[0] = 0; fwd_dvalid[0] = 1;
        fwd_waddr[1] = 5'd7; fwd_wen[1] = 1; fwd_dvalid[1] = 1;
        @(negedge clk); compare_all("loaduse_adv");
        chk("loaduse_adv_stall", 32'(stall), 32'd0);
        chk("loaduse_adv_sel", 32'(fwd_sel[1]), 32'd2);
        chk("loaduse_one_cycle", 32'(stall_cycles), 32'(sc0 + 1));
        tick();

        // Flush with x4 at count 2 beats a simultaneous issue to x6.
        idle_inputs();
        iss_valid = 1; iss_rd = 5'd4; iss_wen = 1; iss_lat = 3'd3;
        tick();
        iss_valid = 0;
        tick();
        flush = 1; iss_valid = 1; iss_rd = 5'd6; iss_wen = 1; iss_lat = 3'd5;
        @(negedge clk); compare_all("flush_pre");
        chk("flush_pre_x4", 32'(pending[4]), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk); compare_all("flush_post");
        chk("flush_post_pending", pending, 32'h0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < int'(NUM_RD); p++) begin
                rd_addr[p] = 5'($urandom_range(0, 7));
                rd_used[p] = 1'($urandom_range(0, 1));
            end
            for (int k = 0; k < int'(NUM_FWD); k++) begin
                fwd_waddr[k]  = 5'($urandom_range(0, 7));
                fwd_wen[k]    = 1'($urandom_range(0, 1));
                fwd_dvalid[k] = ($urandom_range(0, 3) != 0);
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            iss_wen   = ($urandom_range(0, 3) != 0);
            iss_lat   = LAT_W'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 24) == 0);
            @(negedge clk); compare_all($sformatf("rnd%0d", i));
            tick();
        end

        // Saturate the stall counter with a held load-use.
        idle_inputs();
        fwd_waddr[0] = 5'd7; fwd_wen[0] = 1; fwd_dvalid[0] = 0;
        rd_addr[1] = 5'd7; rd_used[1] = 1;
        for (int i = 0; i < int'(CNT_MAX) + 6; i++) tick();
        @(negedge clk); compare_all("sat");
        chk("sat_all_ones", 32'(stall_cycles), 32'(CNT_MAX));
        tick();

        // Asynchronous reset mid-cycle drops an outstanding latency.
        idle_inputs();
        iss_valid = 1; iss_rd = 5'd9; iss_wen = 1; iss_lat = 3'd7;
        tick();
        iss_valid = 0; rd_addr[0] = 5'd9; rd_used[0] = 1;
        @(negedge clk); compare_all("prereset");
        chk("prereset_stall", 32'(stall), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async_pending", pending, 32'h0);
        chk("async_stall", 32'(stall), 32'd0);
        chk("async_stall_cycles", 32'(stall_cycles), 32'd0);
        model_reset();
        rst_n = 1;
        tick();
        @(negedge clk); compare_all("postreset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, meaning number of operand read ports.
REQ-002 SHALL have parameter NUM_FWD, default 2, meaning number of bypass stages; index 0 is the youngest (MEM), index NUM_FWD-1 the oldest (WB).
REQ-003 SHALL have parameter LAT_W, default 3, meaning width of the per-register latency countdown.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the stall statistics counter.
REQ-005 SHALL have ports clk in 1 (single clock, rising edge) and rst_n in 1 (asynchronous, active-low reset).
REQ-006 SHALL have port rd_addr in NUM_RD x 5, meaning source register per read port.
REQ-007 SHALL have port rd_used in NUM_RD, meaning the port's operand is consumed by the issuing instruction.
REQ-008 SHALL have ports fwd_waddr in NUM_FWD x 5, fwd_wen in NUM_FWD and fwd_dvalid in NUM_FWD, meaning the stage's destination, its write enable, and whether its result is ready for bypass.
REQ-009 SHALL have ports iss_valid in 1, iss_rd in 5, iss_wen in 1 and iss_lat in LAT_W, meaning the instruction leaving decode, its destination, and its cycles until forwardable (0 = ALU).
REQ-010 SHALL have port flush in 1, meaning pipeline flush.
REQ-011 SHALL have port fwd_sel out NUM_RD x clog2(NUM_FWD+1), meaning 0 = register file, k = bypass from stage k-1.
REQ-012 SHALL have ports stall out 1, pending out 32 (bitmap of registers with nonzero countdown) and stall_cycles out CNT_W.

Function
REQ-013 SHALL select, per port, the lowest-index stage with fwd_wen=1 and fwd_waddr equal to rd_addr as fwd_sel; if no stage matches, fwd_sel SHALL be 0.
REQ-014 SHALL never forward or stall on register 0: rd_addr=0 gives fwd_sel=0 and no hazard.
REQ-015 SHALL assert stall combinationally when any port with rd_used=1 matches a pending register, or its selected stage has fwd_dvalid=0 (load-use).
REQ-016 SHALL keep fwd_sel and stall independent of the iss_* inputs in the same cycle.
REQ-017 SHALL hold one LAT_W countdown per register 1..31; pending[r] equals (count[r]!=0); pending[0] is always 0.
REQ-018 SHALL load count[iss_rd]=iss_lat on a clock edge with iss_valid=1, stall=0, iss_wen=1 and iss_rd!=0.
REQ-019 SHALL decrement every other nonzero countdown by 1 per cycle, saturating at 0.
REQ-020 SHALL give the issue load priority over the decrement when both target the same register in one cycle.
REQ-021 SHALL clear all countdowns on the next edge when flush=1; flush SHALL override a simultaneous issue.
REQ-022 SHALL increment stall_cycles on each edge with stall=1 and flush=0, saturating at all-ones (no wrap).
REQ-023 SHALL have no internal pipeline delay: a countdown reaching 0 removes its stall in the same cycle the count reads 0.

Reset
REQ-024 SHALL, while rst_n=0, clear every countdown, pending and stall_cycles to 0, independent of clk.
REQ-025 SHALL, on reset mid-operation, discard all outstanding latencies with no stall carried over; stall then depends only on combinational inputs.

Structure
REQ-026 SHALL place the register-address width (5), the register count (32) and the fwd_sel encoding constants (FWD_RF=0) in the shared core package.
REQ-027 SHALL use one sub-module, fwd_port_sel, instantiated NUM_RD times, holding the per-port priority match; the scoreboard and counter stay in the top module.

Verification
REQ-028 SHALL cover: rd_addr[0]=5 with stage0 and stage1 both writing x5 -> fwd_sel[0]=1 (youngest wins).
REQ-029 SHALL cover: stage0 a load to x7 with fwd_dvalid[0]=0, rd_addr[1]=7, rd_used[1]=1 -> stall=1 for exactly 1 cycle; then fwd_sel[1]=2 after advance.
REQ-030 SHALL cover: issue x9 with iss_lat=3, then read x9 -> stall high for 3 cycles, pending[9] falls after the third edge, stall_cycles=3.
REQ-031 SHALL cover: x0 written in all stages and used by both ports -> fwd_sel=0 and stall=0.
REQ-032 SHALL cover: flush asserted with x4 pending (count 2) and a simultaneous issue to x6 -> pending=0 next cycle.
REQ-033 SHALL cover: stall held for 2^CNT_W+5 cycles -> stall_cycles=all-ones; rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately.
